multicycle_ctrl_fsm: RTL and testbench

Multicycle MIPS control unit. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the shared-ALU/shared-memory datapath one step per cycle. This generalises the single-cycle opcode decoder with a parametrised opcode width, an optional bne, a memory-ready stall handshake, illegal-opcode detection and a retired-instruction counter. It sits between the instruction register's opcode field and the multicycle datapath.

---
 rtl/multicycle_ctrl_fsm_if.sv | 77 +++++++
 rtl/multicycle_ctrl_fsm.sv | 228 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multicycle control FSM and its datapath.
// master: control unit (drives controls); slave: datapath/IR/memory side.
interface multicycle_ctrl_fsm_if #(
  parameter int OP_W  = 6,
  parameter int CNT_W = 32
);

  logic [OP_W-1:0]  opcode;
  logic             mem_ready;

  logic             pcwrite;
  logic             pcwritecond;
  logic             branch_ne;
  logic             iord;
  logic             memread;
  logic             memwrite;
  logic             irwrite;
  logic             memtoreg;
  logic             regdst;
  logic             regwrite;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       aluop;
  logic [1:0]       pcsource;

  logic [3:0]       state;
  logic             illegal_op;
  logic             instr_retired;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode,
    input  mem_ready,
    output pcwrite,
    output pcwritecond,
    output branch_ne,
    output iord,
    output memread,
    output memwrite,
    output irwrite,
    output memtoreg,
    output regdst,
    output regwrite,
    output alusrca,
    output alusrcb,
    output aluop,
    output pcsource,
    output state,
    output illegal_op,
    output instr_retired,
    output instr_count
  );

  modport slave (
    output opcode,
    output mem_ready,
    input  pcwrite,
    input  pcwritecond,
    input  branch_ne,
    input  iord,
    input  memread,
    input  memwrite,
    input  irwrite,
    input  memtoreg,
    input  regdst,
    input  regwrite,
    input  alusrca,
    input  alusrcb,
    input  aluop,
    input  pcsource,
    input  state,
    input  illegal_op,
    input  instr_retired,
    input  instr_count
  );

endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS control FSM: fetch/decode/execute/mem/writeback sequencing.
// Ports: clk, reset_n (sync, active low), bus (master: opcode/mem_ready in,
// datapath controls, debug state, illegal_op, instr_retired, instr_count out).
module multicycle_ctrl_fsm #(
  parameter int OP_W       = 6,
  parameter int CNT_W      = 32,
  parameter bit ENABLE_BNE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  multicycle_ctrl_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_RTEXEC = 4'd7,
    S_RTWB   = 4'd8,
    S_BEQ    = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12,
    S_BNE    = 4'd13
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic             op_rtype;
  logic             op_lw;
  logic             op_sw;
  logic             op_addi;
  logic             op_beq;
  logic             op_bne;
  logic             op_j;
  logic             op_legal;

  logic             pcwrite;
  logic             pcwritecond;
  logic             branch_ne;
  logic             iord;
  logic             memread;
  logic             memwrite;
  logic             irwrite;
  logic             memtoreg;
  logic             regdst;
  logic             regwrite;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       aluop;
  logic [1:0]       pcsource;
  logic             illegal_op;
  logic             retired;

  // Full-width compares: any set bit above [5:0] makes the opcode illegal.
  always_comb begin
    op_rtype = (bus.opcode == OP_W'(6'b000000));
    op_lw    = (bus.opcode == OP_W'(6'b100011));
    op_sw    = (bus.opcode == OP_W'(6'b101011));
    op_addi  = (bus.opcode == OP_W'(6'b001000));
    op_beq   = (bus.opcode == OP_W'(6'b000100));
    op_bne   = ENABLE_BNE &&
               (bus.opcode == OP_W'(6'b000101));
    op_j     = (bus.opcode == OP_W'(6'b000010));
    op_legal = op_rtype | op_lw | op_sw | op_addi |
               op_beq | op_bne | op_j;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          op_rtype:     state_d = S_RTEXEC;
          op_lw, op_sw: state_d = S_MEMADR;
          op_addi:      state_d = S_ADDIEX;
          op_beq:       state_d = S_BEQ;
          op_bne:       state_d = S_BNE;
          op_j:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = op_lw ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWR: begin
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_RTEXEC: state_d = S_RTWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB,
      S_RTWB,
      S_ADDIWB,
      S_BEQ,
      S_BNE,
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore decode of the current state; only FETCH/MEMWR look at mem_ready.
  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    branch_ne   = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    pcsource    = 2'b00;
    illegal_op  = 1'b0;
    retired     = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = bus.mem_ready;
        pcwrite = bus.mem_ready;
      end
      S_DECODE: begin
        alusrcb    = 2'b11;
        illegal_op = ~op_legal;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        retired  = 1'b1;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        retired  = bus.mem_ready;
      end
      S_RTEXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_RTWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        retired  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        retired  = 1'b1;
      end
      S_BEQ, S_BNE: begin
        alusrca     = 1'b1;
        aluop       = 2'b01;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
        branch_ne   = (state_q == S_BNE);
        retired     = 1'b1;
      end
      S_JUMP: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
        retired  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q + CNT_W'(retired);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pcwrite       = pcwrite;
  assign bus.pcwritecond   = pcwritecond;
  assign bus.branch_ne     = branch_ne;
  assign bus.iord          = iord;
  assign bus.memread       = memread;
  assign bus.memwrite      = memwrite;
  assign bus.irwrite       = irwrite;
  assign bus.memtoreg      = memtoreg;
  assign bus.regdst        = regdst;
  assign bus.regwrite      = regwrite;
  assign bus.alusrca       = alusrca;
  assign bus.alusrcb       = alusrcb;
  assign bus.aluop         = aluop;
  assign bus.pcsource      = pcsource;
  assign bus.state         = state_q;
  assign bus.illegal_op    = illegal_op;
  assign bus.instr_retired = retired;
  assign bus.instr_count   = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench: two builds (bne on / bne off), OP_W=8, CNT_W=4.
// Instruction-level model expands each instruction into expected cycles.
module tb_multicycle_ctrl_fsm;

  localparam int OP_W  = 8;
  localparam int CNT_W = 4;
  localparam int N     = 250;
  localparam int MAXC  = 20000;

  localparam int S_IDLE   = 0;
  localparam int S_FETCH  = 1;
  localparam int S_DECODE = 2;
  localparam int S_MEMADR = 3;
  localparam int S_MEMRD  = 4;
  localparam int S_MEMWB  = 5;
  localparam int S_MEMWR  = 6;
  localparam int S_RTEXEC = 7;
  localparam int S_RTWB   = 8;
  localparam int S_BEQ    = 9;
  localparam int S_JUMP   = 10;
  localparam int S_ADDIEX = 11;
  localparam int S_ADDIWB = 12;
  localparam int S_BNE    = 13;

  typedef struct packed {
    logic [3:0]       st;
    logic [18:0]      ctl;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic       mr;
    logic [7:0] op;
    exp_t       e;
  } cyc_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  multicycle_ctrl_fsm_if #(.OP_W(OP_W), .CNT_W(CNT_W)) bus_a ();
  multicycle_ctrl_fsm_if #(.OP_W(OP_W), .CNT_W(CNT_W)) bus_b ();

  multicycle_ctrl_fsm #(
    .OP_W(OP_W), .CNT_W(CNT_W), .ENABLE_BNE(1'b1)
  ) dut_a (
    .clk(clk), .reset_n(rst_a), .bus(bus_a.master)
  );

  multicycle_ctrl_fsm #(
    .OP_W(OP_W), .CNT_W(CNT_W), .ENABLE_BNE(1'b0)
  ) dut_b (
    .clk(clk), .reset_n(rst_b), .bus(bus_b.master)
  );

  wire [18:0] act_a = {bus_a.pcwrite, bus_a.pcwritecond, bus_a.branch_ne,
                       bus_a.iord, bus_a.memread, bus_a.memwrite,
                       bus_a.irwrite, bus_a.memtoreg, bus_a.regdst,
                       bus_a.regwrite, bus_a.alusrca, bus_a.alusrcb,
                       bus_a.aluop, bus_a.pcsource, bus_a.illegal_op,
                       bus_a.instr_retired};
  wire [18:0] act_b = {bus_b.pcwrite, bus_b.pcwritecond, bus_b.branch_ne,
                       bus_b.iord, bus_b.memread, bus_b.memwrite,
                       bus_b.irwrite, bus_b.memtoreg, bus_b.regdst,
                       bus_b.regwrite, bus_b.alusrca, bus_b.alusrcb,
                       bus_b.aluop, bus_b.pcsource, bus_b.illegal_op,
                       bus_b.instr_retired};

  cyc_t pend_a[$];
  cyc_t pend_b[$];
  exp_t exp_a[$];
  exp_t exp_b[$];
  int   mcnt[2];
  int   ncmp = 0;
  int   nbad = 0;

  // Directed opening: R, lw with waits, sw, beq, j, bne, wide illegal,
  // sw reset in its first MEMWR stall cycle.
  logic [7:0] d_op [8] = '{8'h00, 8'h23, 8'h2b, 8'h04,
                           8'h02, 8'h05, 8'h40, 8'h2b};
  int d_fw [8] = '{0, 2, 0, 0, 0, 0, 0, 0};
  int d_mw [8] = '{0, 3, 0, 0, 0, 0, 0, 2};
  int d_ab [8] = '{-1, -1, -1, -1, -1, -1, -1, 3};

  function automatic logic [18:0] ctl_of(int st, bit mr, bit ill);
    logic pw, pwc, bn, io, mrd, mwr, irw, m2r, rd, rw, asa, il, ret;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, bn, io, mrd, mwr, irw, m2r, rd, rw, asa, il, ret} = '0;
    {asb, aop, psrc} = '0;
    case (st)
      S_FETCH:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      S_DECODE: begin asb = 2'b11; il = ill; end
      S_MEMADR: begin asa = 1; asb = 2'b10; end
      S_MEMRD:  begin mrd = 1; io = 1; end
      S_MEMWB:  begin rw = 1; m2r = 1; ret = 1; end
      S_MEMWR:  begin mwr = 1; io = 1; ret = mr; end
      S_RTEXEC: begin asa = 1; aop = 2'b10; end
      S_RTWB:   begin rw = 1; rd = 1; ret = 1; end
      S_ADDIEX: begin asa = 1; asb = 2'b10; end
      S_ADDIWB: begin rw = 1; ret = 1; end
      S_BEQ, S_BNE: begin
        asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01;
        bn = (st == S_BNE); ret = 1;
      end
      S_JUMP:   begin pw = 1; psrc = 2'b10; ret = 1; end
      default:  ;
    endcase
    return {pw, pwc, bn, io, mrd, mwr, irw, m2r, rd, rw, asa,
            asb, aop, psrc, il, ret};
  endfunction

  function automatic void push(int k, int st, bit mr, bit ill,
                               bit rst, logic [7:0] op);
    cyc_t c;
    c.rst   = rst;
    c.mr    = mr;
    c.op    = op;
    c.e.st  = 4'(st);
    c.e.ctl = ctl_of(st, mr, ill);
    c.e.cnt = CNT_W'(mcnt[k]);
    if (!rst) mcnt[k] = 0;
    else if (c.e.ctl[0]) mcnt[k] = (mcnt[k] + 1) % (1 << CNT_W);
    if (k == 0) pend_a.push_back(c);
    else pend_b.push_back(c);
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expand one instruction into its cycle sequence. ab: -1 none,
  // -2 random reset point, >=0 reset asserted in that cycle.
  function automatic void gen(int k, logic [7:0] op, int fw, int mw,
                              int ab);
    int sts[$];
    bit mrs[$];
    bit ill;
    bit en;
    int at;
    en  = (k == 0);
    ill = 1'b0;
    for (int i = 0; i < fw; i++) begin sts.push_back(S_FETCH); mrs.push_back(0); end
    sts.push_back(S_FETCH);  mrs.push_back(1);
    sts.push_back(S_DECODE); mrs.push_back(rb());
    if (op == 8'h00) begin
      sts.push_back(S_RTEXEC); mrs.push_back(rb());
      sts.push_back(S_RTWB);   mrs.push_back(rb());
    end else if (op == 8'h23) begin
      sts.push_back(S_MEMADR); mrs.push_back(rb());
      for (int i = 0; i < mw; i++) begin sts.push_back(S_MEMRD); mrs.push_back(0); end
      sts.push_back(S_MEMRD);  mrs.push_back(1);
      sts.push_back(S_MEMWB);  mrs.push_back(rb());
    end else if (op == 8'h2b) begin
      sts.push_back(S_MEMADR); mrs.push_back(rb());
      for (int i = 0; i < mw; i++) begin sts.push_back(S_MEMWR); mrs.push_back(0); end
      sts.push_back(S_MEMWR);  mrs.push_back(1);
    end else if (op == 8'h08) begin
      sts.push_back(S_ADDIEX); mrs.push_back(rb());
      sts.push_back(S_ADDIWB); mrs.push_back(rb());
    end else if (op == 8'h04) begin
      sts.push_back(S_BEQ);    mrs.push_back(rb());
    end else if (op == 8'h05 && en) begin
      sts.push_back(S_BNE);    mrs.push_back(rb());
    end else if (op == 8'h02) begin
      sts.push_back(S_JUMP);   mrs.push_back(rb());
    end else begin
      ill = 1'b1;
    end
    at = (ab == -2) ? int'($urandom_range(0, sts.size() - 1)) : ab;
    for (int i = 0; i < sts.size(); i++) begin
      if (i == at) begin
        push(k, sts[i], mrs[i], ill, 1'b0, op);
        push(k, S_IDLE, rb(), 1'b0, 1'b1, op);
        return;
      end
      push(k, sts[i], mrs[i], ill, 1'b1, op);
    end
  endfunction

  function automatic logic [7:0] legal_op(int i);
    case (i)
      0: return 8'h00;
      1: return 8'h23;
      2: return 8'h2b;
      3: return 8'h08;
      4: return 8'h04;
      5: return 8'h05;
      default: return 8'h02;
    endcase
  endfunction

  function automatic void next_instr(int k, int idx);
    int r;
    logic [7:0] op;
    int fw, mw, ab;
    if (idx < 8) begin
      gen(k, d_op[idx], d_fw[idx], d_mw[idx], d_ab[idx]);
      return;
    end
    r = $urandom_range(0, 9);
    if (r <= 6) op = legal_op(r);
    else if (r == 7) op = 8'($urandom_range(0, 255));
    else if (r == 8) op = legal_op($urandom_range(0, 6)) | 8'h40;
    else op = 8'($urandom_range(0, 63));
    fw = rb() ? 0 : int'($urandom_range(1, 3));
    mw = rb() ? 0 : int'($urandom_range(1, 3));
    ab = ($urandom_range(0, 24) == 0) ? -2 : -1;
    gen(k, op, fw, mw, ab);
  endfunction

  // Monitor: compares every cycle that has an expected entry queued.
  int mcyc = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      mcyc++;
      if (exp_a.size() > 0) begin
        e = exp_a.pop_front();
        ncmp++;
        if ({bus_a.state, act_a, bus_a.instr_count} !== {e.st, e.ctl, e.cnt}) begin
          nbad++;
          $display("FAIL bne_on cyc%0d: got st=%0d ctl=%05h cnt=%0d want st=%0d ctl=%05h cnt=%0d",
                   mcyc, bus_a.state, act_a, bus_a.instr_count, e.st, e.ctl, e.cnt);
        end
      end
      if (exp_b.size() > 0) begin
        e = exp_b.pop_front();
        ncmp++;
        if ({bus_b.state, act_b, bus_b.instr_count} !== {e.st, e.ctl, e.cnt}) begin
          nbad++;
          $display("FAIL bne_off cyc%0d: got st=%0d ctl=%05h cnt=%0d want st=%0d ctl=%05h cnt=%0d",
                   mcyc, bus_b.state, act_b, bus_b.instr_count, e.st, e.ctl, e.cnt);
        end
      end
    end
  end

  // Stimulus: drives inputs #1 after each rising edge, queues expectations.
  initial begin
    cyc_t c;
    int   n[2];
    int   cyc;
    rst_a = 1'b0;
    rst_b = 1'b0;
    bus_a.opcode = '0;
    bus_a.mem_ready = 1'b0;
    bus_b.opcode = '0;
    bus_b.mem_ready = 1'b0;
    mcnt[0] = 0;
    mcnt[1] = 0;
    n[0] = 0;
    n[1] = 0;
    cyc = 0;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      push(k, S_IDLE, 1'b0, 1'b0, 1'b0, 8'h00);
      push(k, S_IDLE, 1'b1, 1'b0, 1'b1, 8'h00);
    end
    while (!(n[0] >= N && pend_a.size() == 0 &&
             n[1] >= N && pend_b.size() == 0) && cyc < MAXC) begin
      if (pend_a.size() == 0 && n[0] < N) begin next_instr(0, n[0]); n[0]++; end
      if (pend_b.size() == 0 && n[1] < N) begin next_instr(1, n[1]); n[1]++; end
      #1;
      if (pend_a.size() > 0) begin
        c = pend_a.pop_front();
        rst_a = c.rst;
        bus_a.opcode = c.op;
        bus_a.mem_ready = c.mr;
        exp_a.push_back(c.e);
      end
      if (pend_b.size() > 0) begin
        c = pend_b.pop_front();
        rst_b = c.rst;
        bus_b.opcode = c.op;
        bus_b.mem_ready = c.mr;
        exp_b.push_back(c.e);
      end
      @(posedge clk);
      cyc++;
    end
    repeat (2) @(posedge clk);
    ncmp++;
    if (cyc >= MAXC) begin
      nbad++;
      $display("FAIL timeout: got %0d cycles, want < %0d", cyc, MAXC);
    end else if (exp_a.size() != 0 || exp_b.size() != 0) begin
      nbad++;
      $display("FAIL drain: got %0d/%0d left, want 0/0", exp_a.size(), exp_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
